// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit bus initiator.
// Holds the load/store op encodings, the controller state enum, the
// AXI OKAY response code and the per-size write-strobe base masks.
package lsu_pkg;

   // Load ops use all five codes; stores only use OP_B/OP_H/OP_W (sb/sh/sw).
   localparam logic [2:0] OP_B  = 3'd0;
   localparam logic [2:0] OP_H  = 3'd1;
   localparam logic [2:0] OP_W  = 3'd2;
   localparam logic [2:0] OP_BU = 3'd4;
   localparam logic [2:0] OP_HU = 3'd5;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   // Strobe masks for a lane-0 access; shifted left by addr[1:0].
   localparam logic [3:0] MASK_B = 4'b0001;
   localparam logic [3:0] MASK_H = 4'b0011;
   localparam logic [3:0] MASK_W = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_RESP = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane handling for the LSU.
//   wen, op, addr_lo : access type, size code and byte offset in the word
//   wdata            : LSB-justified store data
//   rdata            : raw word returned by the responder
//   wdata_lane       : store data moved onto its byte lanes
//   strb             : 4-bit write strobe for the addressed lanes
//   rdata_ext        : load data extracted from its lane and extended
//   bad_req          : misaligned access or op code with no meaning
module lsu_align
   import lsu_pkg::*;
(
   input  logic        wen,
   input  logic [2:0]  op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [31:0] wdata_lane,
   output logic [3:0]  strb,
   output logic [31:0] rdata_ext,
   output logic        bad_req
);

   function automatic logic [31:0] sext8(input logic [7:0] b);
      logic signed [7:0]  s;
      logic signed [31:0] r;
      s = b;
      r = s;
      return r;
   endfunction

   function automatic logic [31:0] sext16(input logic [15:0] h);
      logic signed [15:0] s;
      logic signed [31:0] r;
      s = h;
      r = s;
      return r;
   endfunction

   logic [3:0]  base;
   logic [15:0] lane;

   always_comb begin
      base    = 4'b0000;
      bad_req = 1'b0;
      case (op)
         OP_B:  base = MASK_B;
         OP_H:  begin base = MASK_H; bad_req = addr_lo[0]; end
         OP_W:  begin base = MASK_W; bad_req = |addr_lo;   end
         // Unsigned variants exist only for loads.
         OP_BU: bad_req = wen;
         OP_HU: bad_req = wen | addr_lo[0];
         default: bad_req = 1'b1;
      endcase
   end

   assign strb       = base << addr_lo;
   assign wdata_lane = wdata << {addr_lo, 3'b000};

   // Halfword offsets are only ever 0 or 2 here, so the same shift
   // serves both byte and halfword extraction.
   assign lane = 16'(rdata >> {addr_lo, 3'b000});

   always_comb begin
      case (op)
         OP_B:    rdata_ext = sext8(lane[7:0]);
         OP_H:    rdata_ext = sext16(lane);
         OP_BU:   rdata_ext = {24'd0, lane[7:0]};
         OP_HU:   rdata_ext = {16'd0, lane};
         default: rdata_ext = rdata;
      endcase
   end

endmodule

// File: rtl/lsu_axi_master.sv
// lsu_axi_master: load/store unit bus initiator.
// Accepts one request at a time from the core (req_*), runs it on an
// AXI-lite style read (AR/R) or write (AW/W/B) channel with word-aligned
// addresses, and returns a one-cycle completion (resp_*).
//   clk, rst           : clock, synchronous active-high reset
//   req_valid/ready    : request handshake; req_wen, req_op, req_addr, req_wdata
//   resp_valid         : completion pulse with resp_rdata and resp_err
//   mem_aw*/w*/b*      : write address, write data, write response channels
//   mem_ar*/r*         : read address and read data channels
module lsu_axi_master
   import lsu_pkg::*;
#(
   parameter int STRB_W = 8,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wen,
   input  logic [2:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_awvalid,
   input  logic              mem_awready,
   output logic [ADDR_W-1:0] mem_awaddr,
   output logic              mem_wvalid,
   input  logic              mem_wready,
   output logic [31:0]       mem_wdata,
   output logic [STRB_W-1:0] mem_wstrb,
   input  logic              mem_bvalid,
   output logic              mem_bready,
   input  logic [1:0]        mem_bresp,
   output logic              mem_arvalid,
   input  logic              mem_arready,
   output logic [ADDR_W-1:0] mem_araddr,
   input  logic              mem_rvalid,
   output logic              mem_rready,
   input  logic [1:0]        mem_rresp,
   input  logic [31:0]       mem_rdata
);

   lsu_state_t  state;
   logic        wen_q;
   logic [2:0]  op_q;
   logic [1:0]  lo_q;
   logic        aw_done, w_done, b_done, berr_q;

   // In IDLE the aligner judges the incoming request; afterwards it works
   // on the latched op/offset so load extraction sees the accepted access.
   logic        sel_wen;
   logic [2:0]  sel_op;
   logic [1:0]  sel_lo;
   logic [31:0] wdata_lane, rdata_ext;
   logic [3:0]  strb;
   logic        bad_req;

   assign sel_wen = (state == ST_IDLE) ? req_wen       : wen_q;
   assign sel_op  = (state == ST_IDLE) ? req_op        : op_q;
   assign sel_lo  = (state == ST_IDLE) ? req_addr[1:0] : lo_q;

   lsu_align u_align (
      .wen        (sel_wen),
      .op         (sel_op),
      .addr_lo    (sel_lo),
      .wdata      (req_wdata),
      .rdata      (mem_rdata),
      .wdata_lane (wdata_lane),
      .strb       (strb),
      .rdata_ext  (rdata_ext),
      .bad_req    (bad_req)
   );

   logic aw_hs, w_hs, b_hs, r_hs, wr_fin;
   assign aw_hs  = mem_awvalid & mem_awready;
   assign w_hs   = mem_wvalid  & mem_wready;
   assign b_hs   = mem_bvalid  & mem_bready;
   assign r_hs   = mem_rvalid  & mem_rready;
   // The B handshake may land in the same cycle as the last AW/W handshake.
   assign wr_fin = (aw_done | aw_hs) & (w_done | w_hs) & (b_done | b_hs);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         req_ready   <= 1'b1;
         resp_valid  <= 1'b0;
         resp_err    <= 1'b0;
         resp_rdata  <= '0;
         mem_awvalid <= 1'b0;
         mem_wvalid  <= 1'b0;
         mem_bready  <= 1'b0;
         mem_arvalid <= 1'b0;
         mem_rready  <= 1'b0;
         mem_awaddr  <= '0;
         mem_araddr  <= '0;
         mem_wdata   <= '0;
         mem_wstrb   <= '0;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
         b_done      <= 1'b0;
         berr_q      <= 1'b0;
         wen_q       <= 1'b0;
         op_q        <= '0;
         lo_q        <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  wen_q     <= req_wen;
                  op_q      <= req_op;
                  lo_q      <= req_addr[1:0];
                  if (bad_req) begin
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                     state      <= ST_RESP;
                  end else if (req_wen) begin
                     mem_awvalid <= 1'b1;
                     mem_wvalid  <= 1'b1;
                     // Responder needs bready during the address phase.
                     mem_bready  <= 1'b1;
                     mem_awaddr  <= {req_addr[ADDR_W-1:2], 2'b00};
                     mem_wdata   <= wdata_lane;
                     mem_wstrb   <= {{(STRB_W-4){1'b0}}, strb};
                     aw_done     <= 1'b0;
                     w_done      <= 1'b0;
                     b_done      <= 1'b0;
                     berr_q      <= 1'b0;
                     state       <= ST_WR;
                  end else begin
                     mem_arvalid <= 1'b1;
                     mem_rready  <= 1'b1;
                     mem_araddr  <= {req_addr[ADDR_W-1:2], 2'b00};
                     state       <= ST_RD;
                  end
               end
            end

            ST_RD: begin
               if (mem_arvalid && mem_arready) mem_arvalid <= 1'b0;
               if (r_hs) begin
                  mem_arvalid <= 1'b0;
                  mem_rready  <= 1'b0;
                  resp_valid  <= 1'b1;
                  if (mem_rresp != RESP_OKAY) begin
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else begin
                     resp_err   <= 1'b0;
                     resp_rdata <= rdata_ext;
                  end
                  state <= ST_RESP;
               end
            end

            ST_WR: begin
               if (aw_hs) begin mem_awvalid <= 1'b0; aw_done <= 1'b1; end
               if (w_hs)  begin mem_wvalid  <= 1'b0; w_done  <= 1'b1; end
               if (b_hs) begin
                  mem_bready <= 1'b0;
                  b_done     <= 1'b1;
                  berr_q     <= (mem_bresp != RESP_OKAY);
               end
               if (wr_fin) begin
                  mem_bready <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_rdata <= '0;
                  resp_err   <= b_hs ? (mem_bresp != RESP_OKAY) : berr_q;
                  state      <= ST_RESP;
               end
            end

            ST_RESP: begin
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
               req_ready  <= 1'b1;
               state      <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_axi_master.sv
`timescale 1ns/1ps
module tb_lsu_axi_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_wen;
   logic [2:0]  req_op;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_awvalid, mem_awready;
   logic [31:0] mem_awaddr;
   logic        mem_wvalid, mem_wready;
   logic [31:0] mem_wdata;
   logic [7:0]  mem_wstrb;
   logic        mem_bvalid, mem_bready;
   logic [1:0]  mem_bresp;
   logic        mem_arvalid, mem_arready;
   logic [31:0] mem_araddr;
   logic        mem_rvalid, mem_rready;
   logic [1:0]  mem_rresp;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   lsu_axi_master #(.STRB_W(8), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_awvalid(mem_awvalid), .mem_awready(mem_awready), .mem_awaddr(mem_awaddr),
      .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb),
      .mem_bvalid(mem_bvalid), .mem_bready(mem_bready), .mem_bresp(mem_bresp),
      .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
      .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rresp(mem_rresp),
      .mem_rdata(mem_rdata)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;   // accept-to-resp cycles, -1 = not checked
   } exp_t;

   exp_t sb[$];
   int errors   = 0;
   int checks   = 0;
   int resp_cnt = 0;
   int cyc      = 0;
   int acc_cyc  = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst && req_valid && req_ready) acc_cyc <= cyc;
   end

   // Scoreboard: every completion pulse is matched to the oldest request.
   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst && resp_valid) begin
         resp_cnt++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp: resp_valid=1 rdata=%h err=%0b, required no response", resp_rdata, resp_err);
         end else begin
            e = sb.pop_front();
            if (resp_rdata !== e.rdata || resp_err !== e.err) begin
               errors++;
               $display("FAIL resp_data: rdata=%h err=%0b, required rdata=%h err=%0b", resp_rdata, resp_err, e.rdata, e.err);
            end
            if (e.lat >= 0) begin
               checks++;
               if (cyc - acc_cyc != e.lat) begin
                  errors++;
                  $display("FAIL latency: %0d cycles, required %0d", cyc - acc_cyc, e.lat);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input int lat);
      exp_t e;
      int   n = 0;
      while (req_ready !== 1'b1 && n < 100) begin step(); n++; end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL issue_ready: req_ready=%0b after %0d cycles, required 1", req_ready, n);
      end
      e.rdata = exp_rd; e.err = exp_err; e.lat = lat;
      sb.push_back(e);
      req_valid = 1'b1; req_wen = wen; req_op = op; req_addr = addr; req_wdata = wd;
      step();
      req_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while ((sb.size() != 0 || req_ready !== 1'b1) && n < 100) begin step(); n++; end
      checks++;
      if (sb.size() != 0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_done: pending=%0d req_ready=%0b, required 0 and 1", tag, sb.size(), req_ready);
         sb.delete();
      end
   endtask

   task automatic do_read(input int ar_dly, input int r_dly, input logic [31:0] rd,
                          input logic [1:0] rr, input logic [31:0] exp_addr);
      int n = 0;
      while (mem_arvalid !== 1'b1 && n < 100) begin step(); n++; end
      checks++;
      if (mem_arvalid !== 1'b1 || mem_araddr !== exp_addr) begin
         errors++;
         $display("FAIL araddr: arvalid=%0b araddr=%h, required 1 %h", mem_arvalid, mem_araddr, exp_addr);
      end
      repeat (ar_dly) step();
      mem_arready = 1'b1;
      step();
      mem_arready = 1'b0;
      checks++;
      if (mem_arvalid !== 1'b0) begin
         errors++;
         $display("FAIL ar_drop: arvalid=%0b after handshake, required 0", mem_arvalid);
      end
      repeat (r_dly) step();
      mem_rvalid = 1'b1; mem_rdata = rd; mem_rresp = rr;
      step();
      mem_rvalid = 1'b0; mem_rresp = 2'b00;
   endtask

   task automatic do_write(input int aw_at, input int w_at, input int b_at, input logic [1:0] br,
                           input logic [31:0] exp_addr, input logic [31:0] exp_wd,
                           input logic [7:0] exp_strb);
      int n = 0;
      int pre;
      while (mem_awvalid !== 1'b1 && n < 100) begin step(); n++; end
      checks++;
      if (mem_awvalid !== 1'b1 || mem_wvalid !== 1'b1 || mem_bready !== 1'b1 ||
          mem_awaddr !== exp_addr || mem_wdata !== exp_wd || mem_wstrb !== exp_strb) begin
         errors++;
         $display("FAIL wr_entry: aw/w/b=%0b%0b%0b awaddr=%h wdata=%h wstrb=%h, required 111 %h %h %h",
                  mem_awvalid, mem_wvalid, mem_bready, mem_awaddr, mem_wdata, mem_wstrb,
                  exp_addr, exp_wd, exp_strb);
      end
      pre = resp_cnt;
      for (int i = 0; i <= b_at; i++) begin
         mem_awready = (i == aw_at);
         mem_wready  = (i == w_at);
         mem_bvalid  = (i == b_at);
         mem_bresp   = (i == b_at) ? br : 2'b00;
         step();
         if (i == aw_at) begin
            checks++;
            if (mem_awvalid !== 1'b0) begin
               errors++;
               $display("FAIL aw_drop: awvalid=%0b, required 0", mem_awvalid);
            end
         end
         if (i == w_at) begin
            checks++;
            if (mem_wvalid !== 1'b0) begin
               errors++;
               $display("FAIL w_drop: wvalid=%0b, required 0", mem_wvalid);
            end
         end
      end
      mem_awready = 1'b0; mem_wready = 1'b0; mem_bvalid = 1'b0; mem_bresp = 2'b00;
      checks++;
      if (resp_cnt != pre || resp_valid !== 1'b1) begin
         errors++;
         $display("FAIL b_resp: early responses=%0d resp_valid=%0b, required 0 and 1", resp_cnt - pre, resp_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 0; req_wen = 0; req_op = 0; req_addr = 0; req_wdata = 0;
      mem_awready = 0; mem_wready = 0; mem_bvalid = 0; mem_bresp = 0;
      mem_arready = 0; mem_rvalid = 0; mem_rresp = 0; mem_rdata = 0;
      repeat (3) step();
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0) begin
         errors++;
         $display("FAIL rst_core: req_ready=%0b resp_valid=%0b resp_err=%0b, required 1 0 0", req_ready, resp_valid, resp_err);
      end
      checks++;
      if ({mem_awvalid, mem_wvalid, mem_bready, mem_arvalid, mem_rready} !== 5'b0) begin
         errors++;
         $display("FAIL rst_valids: aw/w/b/ar/r=%b, required 00000",
                  {mem_awvalid, mem_wvalid, mem_bready, mem_arvalid, mem_rready});
      end
      checks++;
      if (mem_awaddr !== 0 || mem_araddr !== 0 || mem_wdata !== 0 || mem_wstrb !== 0 || resp_rdata !== 0) begin
         errors++;
         $display("FAIL rst_data: awaddr=%h araddr=%h wdata=%h wstrb=%h rdata=%h, required all 0",
                  mem_awaddr, mem_araddr, mem_wdata, mem_wstrb, resp_rdata);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_lw_delay();
      issue(1'b0, 3'd2, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, -1);
      do_read(0, 5, 32'hDEAD_BEEF, 2'b00, 32'h8000_0004);
      wait_done("lw_delay");
   endtask

   task automatic test_lb_lbu();
      issue(1'b0, 3'd0, 32'h8000_0003, 32'h0, 32'hFFFF_FF80, 1'b0, -1);
      do_read(1, 0, 32'h80FF_0000, 2'b00, 32'h8000_0000);
      wait_done("lb");
      issue(1'b0, 3'd4, 32'h8000_0003, 32'h0, 32'h0000_0080, 1'b0, -1);
      do_read(0, 2, 32'h80FF_0000, 2'b00, 32'h8000_0000);
      wait_done("lbu");
   endtask

   task automatic test_sh();
      issue(1'b1, 3'd1, 32'h8000_0002, 32'h1234_ABCD, 32'h0, 1'b0, -1);
      do_write(0, 3, 13, 2'b00, 32'h8000_0000, 32'hABCD_0000, 8'h0C);
      wait_done("sh");
   endtask

   task automatic test_misaligned();
      issue(1'b0, 3'd2, 32'h8000_0001, 32'h0, 32'h0, 1'b1, 1);
      checks++;
      if (mem_arvalid !== 1'b0 || resp_valid !== 1'b1) begin
         errors++;
         $display("FAIL mis_lw: arvalid=%0b resp_valid=%0b, required 0 1", mem_arvalid, resp_valid);
      end
      wait_done("mis_lw");
      issue(1'b1, 3'd2, 32'h8000_0002, 32'h5555_5555, 32'h0, 1'b1, 1);
      checks++;
      if (mem_awvalid !== 1'b0 || mem_wvalid !== 1'b0) begin
         errors++;
         $display("FAIL mis_sw: awvalid=%0b wvalid=%0b, required 0 0", mem_awvalid, mem_wvalid);
      end
      wait_done("mis_sw");
      issue(1'b0, 3'd5, 32'h8000_0003, 32'h0, 32'h0, 1'b1, 1);
      wait_done("mis_lhu");
      issue(1'b0, 3'd3, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 1);
      checks++;
      if (mem_arvalid !== 1'b0) begin
         errors++;
         $display("FAIL bad_op: arvalid=%0b, required 0", mem_arvalid);
      end
      wait_done("bad_op");
   endtask

   task automatic test_err_resp();
      issue(1'b1, 3'd2, 32'h8000_0008, 32'h1122_3344, 32'h0, 1'b1, -1);
      do_write(0, 0, 1, 2'b10, 32'h8000_0008, 32'h1122_3344, 8'h0F);
      wait_done("sw_bresp");
      issue(1'b0, 3'd5, 32'h8000_0002, 32'h0, 32'h0, 1'b1, -1);
      do_read(0, 0, 32'hFFFF_1234, 2'b10, 32'h8000_0000);
      wait_done("lhu_rresp");
   endtask

   task automatic test_back_to_back();
      issue(1'b0, 3'd2, 32'h0000_0100, 32'h0, 32'h1234_5678, 1'b0, 3);
      do_read(0, 0, 32'h1234_5678, 2'b00, 32'h0000_0100);
      wait_done("b2b_lw");
      issue(1'b0, 3'd1, 32'h0000_0102, 32'h0, 32'hFFFF_8001, 1'b0, 3);
      do_read(0, 0, 32'h8001_7FFF, 2'b00, 32'h0000_0100);
      wait_done("b2b_lh");
      issue(1'b0, 3'd5, 32'h0000_0100, 32'h0, 32'h0000_F00D, 1'b0, -1);
      do_read(0, 0, 32'h8001_F00D, 2'b00, 32'h0000_0100);
      wait_done("b2b_lhu");
      issue(1'b1, 3'd0, 32'h0000_0201, 32'hFFFF_FFA5, 32'h0, 1'b0, -1);
      do_write(0, 0, 0, 2'b00, 32'h0000_0200, 32'hFFFF_A500, 8'h02);
      wait_done("b2b_sb");
   endtask

   task automatic test_reset_mid();
      int pre;
      issue(1'b0, 3'd2, 32'h8000_0010, 32'h0, 32'h0, 1'b0, -1);
      step();
      checks++;
      if (mem_arvalid !== 1'b1) begin
         errors++;
         $display("FAIL mid_arvalid: arvalid=%0b before reset, required 1", mem_arvalid);
      end
      sb.delete();
      pre = resp_cnt;
      rst = 1'b1;
      step();
      checks++;
      if ({mem_awvalid, mem_wvalid, mem_bready, mem_arvalid, mem_rready, resp_valid} !== 6'b0 ||
          req_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset: aw/w/b/ar/r/resp=%b req_ready=%0b, required 000000 1",
                  {mem_awvalid, mem_wvalid, mem_bready, mem_arvalid, mem_rready, resp_valid}, req_ready);
      end
      rst = 1'b0;
      repeat (4) step();
      checks++;
      if (resp_cnt != pre || mem_arvalid !== 1'b0) begin
         errors++;
         $display("FAIL mid_noresp: responses=%0d arvalid=%0b, required 0 0", resp_cnt - pre, mem_arvalid);
      end
   endtask

   initial begin
      test_reset();
      test_lw_delay();
      test_lb_lbu();
      test_sh();
      test_misaligned();
      test_err_resp();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

endmodule
